// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch queue: reset/trap vectors,
// redirect-select bit positions, NOP encoding and redirect-source enum.
package if_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR_DEF   = 32'h0000_0004;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0008;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam int SEL_BRANCH = 2;
  localparam int SEL_JUMP   = 1;
  localparam int SEL_JR     = 0;
  localparam int ST_IRQ     = 1;
  localparam int ST_EXC     = 0;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_JR,
    SRC_IRQ,
    SRC_EXC
  } redir_src_e;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response and ID-side handshake bundle.
// master = fetch stage, slave = memory/ID environment.
interface if_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc_plus4, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc_plus4, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );
endinterface

// File: rtl/if_fq_fifo.sv
// Synchronous FIFO with synchronous clear; storage is not reset, only
// pointers and occupancy. Push while full is accepted only alongside a pop.
module if_fq_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage with a credit-checked fetch queue in front of ID.
// Optional macro IF_FETCH_PERF_EN adds stall/flush performance counters.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] IRQ_VECTOR      = XLEN'(IRQ_VECTOR_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR      = XLEN'(EXC_VECTOR_DEF)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  sel_next,
  input  logic [XLEN-1:0]             branch_target,
  input  logic [XLEN-1:0]             jump_target,
  input  logic [XLEN-1:0]             jr_target,
  input  logic [1:0]                  status,
  if_fetch_queue_if.master            bus,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_flush_count
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  // Kernel bit is sticky; only the low bits advance and wrap.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc_in);
    return {pc_in[XLEN-1], pc_in[XLEN-2:0] + (XLEN-1)'(4)};
  endfunction

  redir_src_e      src;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_keep;
  logic            pop;
  logic [EW-1:0]   fifo_din;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_empty;

  always_comb begin
    src = SRC_NONE;
    if      (sel_next[SEL_BRANCH]) src = SRC_BRANCH;
    else if (sel_next[SEL_JUMP])   src = SRC_JUMP;
    else if (sel_next[SEL_JR])     src = SRC_JR;
    else if (status[ST_IRQ])       src = SRC_IRQ;
    else if (status[ST_EXC])       src = SRC_EXC;
  end

  always_comb begin
    target = pc;
    case (src)
      SRC_BRANCH: target = branch_target;
      SRC_JUMP:   target = jump_target;
      SRC_JR:     target = jr_target;
      SRC_IRQ:    target = IRQ_VECTOR;
      SRC_EXC:    target = EXC_VECTOR;
      default:    target = pc;
    endcase
  end

  assign redirect = (src != SRC_NONE);

  // Credit check: every in-flight request already owns a queue slot.
  assign bus.imem_req_valid = rst_n & ~redirect
                            & (outstanding < CW'(MAX_OUTSTANDING))
                            & (({1'b0, fq_count} + {1'b0, outstanding}) < (CW+1)'(FQ_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid & (outstanding != '0);
  assign rsp_keep = rsp_ok & (discard == '0) & ~redirect;
  assign pop      = bus.out_valid & bus.out_ready & ~redirect;
  assign fifo_din = {pc_plus4(rsp_pc), bus.imem_rsp_data};

  // rsp_pc tracks the address of the next response that will be kept,
  // so no per-request address queue is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (redirect) begin
        pc      <= target;
        rsp_pc  <= target;
        discard <= outstanding - CW'(rsp_ok);
      end else begin
        if (req_fire) pc <= pc_plus4(pc);
        if (rsp_keep) rsp_pc <= pc_plus4(rsp_pc);
        if (rsp_ok && discard != '0) discard <= discard - CW'(1);
      end
    end
  end

  if_fq_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect),
    .push  (rsp_keep),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fq_count),
    .empty (fifo_empty)
  );

  assign bus.out_valid    = ~fifo_empty;
  assign bus.out_pc_plus4 = bus.out_valid ? fifo_dout[EW-1:XLEN] : XLEN'(NOP);
  assign bus.out_instr    = bus.out_valid ? fifo_dout[XLEN-1:0]  : XLEN'(NOP);

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!bus.imem_req_valid && !redirect && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect && !(&perf_flush_count))
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule
